// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// parity mode encodings and small sizing/parity helpers.
package uart_pkg;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_e;

  // Parity mode encodings for the PARITY parameter.
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Widest supported data word; parity helper operates on this width.
  localparam int MAX_DATA_BITS = 9;

  // Width of a counter that must be able to hold the value data_bits.
  function automatic int bit_cnt_width(input int data_bits);
    return $clog2(data_bits + 1);
  endfunction

  // Returns 1 when the received parity bit disagrees with the data word.
  // Unused upper data bits must be zero. odd_mode selects odd parity.
  function automatic logic parity_mismatch(
    input logic [MAX_DATA_BITS-1:0] data,
    input logic                     rx_bit,
    input logic                     odd_mode
  );
    return rx_bit ^ (^data) ^ odd_mode;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin followed by a
// falling-edge detector. All flops reset high so leaving reset can never
// look like a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rx,
  output logic o_rx_sync,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronise the pin and keep one cycle of history for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rx_sync = r_sync;
  assign o_fall    = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx_fsm.sv
// Bit-level UART receiver. Re-phases the external baud counter on each
// start edge via o_load, then samples start, data (LSB first), optional
// parity and stop bits on i_tick, and emits a one-cycle result strobe
// with frame and parity error flags.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_rx,
  input  logic                 i_tick,
  output logic                 o_load,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_busy
);

  localparam int             CW       = bit_cnt_width(DATA_BITS);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(DATA_BITS);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic           ODD_MODE = (PARITY == PAR_ODD) ? 1'b1 : 1'b0;

  // Synchroniser outputs.
  logic w_rx_sync;
  logic w_fall;

  // FSM state and control strobes.
  state_e r_state;
  state_e w_state_nxt;
  logic   w_tick;
  logic   w_load_set;
  logic   w_cnt_clr;
  logic   w_shift_en;
  logic   w_par_latch;
  logic   w_valid_set;

  // Datapath registers.
  logic [CW-1:0]            r_cnt;
  logic [DATA_BITS-1:0]     r_shift;
  logic                     r_par_err;
  logic [MAX_DATA_BITS-1:0] w_par_data;

  // Registered outputs.
  logic                 r_load;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_parity_err;
  logic                 r_busy;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rx      (i_rx),
    .o_rx_sync (w_rx_sync),
    .o_fall    (w_fall)
  );

  // A tick coinciding with the load pulse belongs to the old baud phase.
  assign w_tick = i_tick & ~r_load;

  // Next-state and control decode for the receive sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_load_set  = 1'b0;
    w_cnt_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_par_latch = 1'b0;
    w_valid_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_nxt = ST_START;
          w_load_set  = 1'b1;
          w_cnt_clr   = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (w_rx_sync) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift_en = 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          w_par_latch = 1'b1;
          w_state_nxt = ST_STOP;
        end else begin
          w_state_nxt = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          w_valid_set = 1'b1;
          if (w_rx_sync) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_BREAK;
          end
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_BREAK: begin
        // Line held low: no edge detection until it returns high.
        if (w_rx_sync) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BREAK;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Zero-extend the received word for the parity helper.
  always_comb begin
    w_par_data                = '0;
    w_par_data[DATA_BITS-1:0] = r_shift;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bit counter: cleared on start edge, saturates at DATA_BITS.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_shift_en && (r_cnt != CNT_FULL)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Shift register: LSB arrives first, so new bits enter at the MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift <= '0;
    end else if (w_shift_en) begin
      r_shift <= {w_rx_sync, r_shift[DATA_BITS-1:1]};
    end
  end

  // Latched parity mismatch for the current frame; stays 0 with no parity.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par_err <= 1'b0;
    end else if (w_cnt_clr) begin
      r_par_err <= 1'b0;
    end else if (w_par_latch) begin
      r_par_err <= parity_mismatch(w_par_data, w_rx_sync, ODD_MODE);
    end
  end

  // One-cycle strobes and the busy flag, all registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_load  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_load  <= w_load_set;
      r_valid <= w_valid_set;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Result word and error flags, updated only on frame completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else if (w_valid_set) begin
      r_data       <= r_shift;
      r_frame_err  <= ~w_rx_sync;
      r_parity_err <= r_par_err;
    end
  end

  assign o_load       = r_load;
  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_frame_err  = r_frame_err;
  assign o_parity_err = r_parity_err;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: three instances (no/even/odd parity), each with
// a behavioural baud counter, driven by directed vectors, corner-case
// sequences and random frames checked against a frame-level model.
module tb_uart_rx_fsm;

  localparam int BIT      = 16;
  localparam int LOAD_VAL = 5;
  localparam int NI       = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rx_a    [NI];
  logic       tick_a  [NI];
  logic       load_a  [NI];
  logic [7:0] data_a  [NI];
  logic       valid_a [NI];
  logic       fe_a    [NI];
  logic       pe_a    [NI];
  logic       busy_a  [NI];

  int         bcnt      [NI];
  int         load_cnt  [NI];
  int         valid_cnt [NI];
  logic [9:0] hist      [NI][16];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_rx_fsm #(.DATA_BITS(8), .PARITY(g)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_rx         (rx_a[g]),
      .i_tick       (tick_a[g]),
      .o_load       (load_a[g]),
      .o_data       (data_a[g]),
      .o_valid      (valid_a[g]),
      .o_frame_err  (fe_a[g]),
      .o_parity_err (pe_a[g]),
      .o_busy       (busy_a[g])
    );
    assign tick_a[g] = (bcnt[g] == 0);
  end

  // Baud counter model: load re-phases so the first tick lands mid-start-bit.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (load_a[k])         bcnt[k] <= LOAD_VAL;
      else if (bcnt[k] == 0) bcnt[k] <= BIT - 1;
      else                   bcnt[k] <= bcnt[k] - 1;
    end
  end

  // Monitor: count load pulses and record every result strobe.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (load_a[k] === 1'b1) load_cnt[k] <= load_cnt[k] + 1;
      if (valid_a[k] === 1'b1) begin
        hist[k][valid_cnt[k] % 16] <= {fe_a[k], pe_a[k], data_a[k]};
        valid_cnt[k] <= valid_cnt[k] + 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: parity error from the frame's own ones count.
  function automatic logic ref_parity_err(input int mode, input logic [7:0] d, input logic pbit);
    int ones;
    logic want;
    ones = $countones(d);
    if (mode == 0) return 1'b0;
    want = (mode == 1) ? logic'(ones % 2) : logic'(1 - (ones % 2));
    return pbit != want;
  endfunction

  task automatic drive_bit(input int inst, input logic b);
    rx_a[inst] = b;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int inst, input logic [7:0] d, input logic pbit, input logic stop);
    drive_bit(inst, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(inst, d[i]);
    if (inst != 0) drive_bit(inst, pbit);
    drive_bit(inst, stop);
  endtask

  task automatic wait_valids(input int inst, input int target);
    for (int t = 0; t < 4 * BIT && valid_cnt[inst] < target; t++) @(posedge clk);
    #1;
  endtask

  // One frame plus optional held-low time and idle, then full result check.
  task automatic frame_test(input string name, input int inst, input logic [7:0] d,
                            input logic pbit, input logic stop, input int hold,
                            input logic [7:0] e_data, input logic e_fe, input logic e_pe);
    int lc, vc;
    logic [9:0] h;
    lc = load_cnt[inst];
    vc = valid_cnt[inst];
    send_frame(inst, d, pbit, stop);
    for (int i = 0; i < hold; i++) drive_bit(inst, 1'b0);
    drive_bit(inst, 1'b1);
    drive_bit(inst, 1'b1);
    wait_valids(inst, vc + 1);
    h = hist[inst][vc % 16];
    check({name, ".valid_count"}, valid_cnt[inst], vc + 1);
    check({name, ".data"},        int'(h[7:0]), int'(e_data));
    check({name, ".frame_err"},   int'(h[9]), int'(e_fe));
    check({name, ".parity_err"},  int'(h[8]), int'(e_pe));
    check({name, ".load_count"},  load_cnt[inst], lc + 1);
    check({name, ".busy_idle"},   int'(busy_a[inst]), 0);
  endtask

  task automatic check_reset_outputs(input string name, input int inst);
    check({name, ".load"},  int'(load_a[inst]), 0);
    check({name, ".data"},  int'(data_a[inst]), 0);
    check({name, ".valid"}, int'(valid_a[inst]), 0);
    check({name, ".fe"},    int'(fe_a[inst]), 0);
    check({name, ".pe"},    int'(pe_a[inst]), 0);
    check({name, ".busy"},  int'(busy_a[inst]), 0);
  endtask

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    int         hold;
    logic [7:0] e_data;
    logic       e_fe;
    logic       e_pe;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int lc, vc;
    logic [7:0] rd;
    logic rp, rs;
    int rh, ri;

    vecs[0] = '{0, 8'h55, 1'b0, 1'b1, 0, 8'h55, 1'b0, 1'b0};
    vecs[1] = '{1, 8'hA3, 1'b1, 1'b1, 0, 8'hA3, 1'b0, 1'b1};
    vecs[2] = '{2, 8'hA3, 1'b1, 1'b1, 0, 8'hA3, 1'b0, 1'b0};
    vecs[3] = '{0, 8'h3C, 1'b0, 1'b0, 3, 8'h3C, 1'b1, 1'b0};
    vecs[4] = '{1, 8'h0F, 1'b0, 1'b1, 0, 8'h0F, 1'b0, 1'b0};
    vecs[5] = '{2, 8'h01, 1'b1, 1'b0, 1, 8'h01, 1'b1, 1'b1};

    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) rx_a[k] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) check_reset_outputs($sformatf("reset%0d", k), k);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Directed vectors.
    for (int v = 0; v < 6; v++)
      frame_test($sformatf("vec%0d", v), vecs[v].inst, vecs[v].data, vecs[v].pbit,
                 vecs[v].stop, vecs[v].hold, vecs[v].e_data, vecs[v].e_fe, vecs[v].e_pe);

    // Glitch shorter than half a bit: one load, no result, busy drops.
    lc = load_cnt[0];
    vc = valid_cnt[0];
    rx_a[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("glitch.busy_high", int'(busy_a[0]), 1);
    rx_a[0] = 1'b1;
    repeat (3 * BIT) @(posedge clk);
    #1;
    check("glitch.load_count",  load_cnt[0], lc + 1);
    check("glitch.valid_count", valid_cnt[0], vc);
    check("glitch.busy_low",    int'(busy_a[0]), 0);

    // Back-to-back frames with zero idle gap.
    lc = load_cnt[0];
    vc = valid_cnt[0];
    send_frame(0, 8'h00, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b1);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    wait_valids(0, vc + 2);
    check("b2b.valid_count", valid_cnt[0], vc + 2);
    check("b2b.first",       int'(hist[0][vc % 16]), 10'h000);
    check("b2b.second",      int'(hist[0][(vc + 1) % 16]), 10'h0FF);
    check("b2b.load_count",  load_cnt[0], lc + 2);

    // Random frames against the frame-level model.
    for (int r = 0; r < 24; r++) begin
      ri = r % NI;
      rd = 8'($urandom);
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 3) != 0);
      rh = rs ? 0 : int'($urandom_range(0, 2));
      frame_test($sformatf("rnd%0d", r), ri, rd, rp, rs, rh,
                 rd, ~rs, ref_parity_err(ri, rd, rp));
    end

    // Reset in the middle of the data bits.
    vc = valid_cnt[0];
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset", 0);
    rx_a[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3 * BIT) @(posedge clk);
    #1;
    check("midreset.no_valid", valid_cnt[0], vc);
    frame_test("after_reset", 0, 8'hC5, 1'b0, 1'b1, 0, 8'hC5, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
